mips_mem_arbiter: RTL and testbench

Two-master arbiter that shares one unified memory port between the MIPS CPU instruction-fetch path and its load/store data path. It is used when the CPU is built against a single-ported memory instead of split instruction/data memories. It serialises accesses, prioritises data accesses, and bounds instruction-fetch starvation with a streak counter. Each access runs as a hold-until-ack transaction on the requester side and a hold-until-not-waitrequest transaction on the memory side.

---
 rtl/mips_mem_arbiter.sv | 127 ++++++++++++
 tb/tb_mips_mem_arbiter.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_mem_arbiter.sv
// Purpose : shares one memory port between the instruction-fetch and load/store
//           paths; data has priority, fetch starvation bounded by a streak counter.
// Latency : ack 1 + N cycles after request is sampled in IDLE (N = waitrequest cycles),
//           one dead IDLE cycle always separates accesses.
// Backpressure: requesters hold req until their ack; mem_* held stable while
//           mem_waitrequest is high.
// Ports:
//   clk, reset          - clock, async active-low reset
//   i_req/i_addr        - fetch request in;  i_ack/i_readdata - fetch completion out
//   d_req/d_write/d_addr/d_writedata/d_byteenable - data request in
//   d_ack/d_readdata    - data completion out
//   mem_*               - unified memory port; mem_waitrequest stalls the access
//   grant               - debug owner: 00 none, 01 instruction, 10 data
module mips_mem_arbiter #(
  parameter int MAX_DATA_STREAK = 4,
  parameter int STREAK_W        = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic        i_ack,
  output logic [31:0] i_readdata,
  input  logic        d_req,
  input  logic        d_write,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_writedata,
  input  logic [3:0]  d_byteenable,
  output logic        d_ack,
  output logic [31:0] d_readdata,
  output logic [31:0] mem_address,
  output logic        mem_read,
  output logic        mem_write,
  output logic [31:0] mem_writedata,
  output logic [3:0]  mem_byteenable,
  input  logic        mem_waitrequest,
  input  logic [31:0] mem_readdata,
  output logic [1:0]  grant
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2
  } state_t;

  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_DATA_STREAK);

  state_t              state, state_nxt;
  logic [STREAK_W-1:0] streak, streak_nxt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      streak <= '0;
    end else begin
      state  <= state_nxt;
      streak <= streak_nxt;
    end
  end

  // All outputs are decoded from the current state only; since reset forces
  // IDLE asynchronously, every output falls to 0 the moment reset asserts.
  always_comb begin
    state_nxt      = state;
    streak_nxt     = streak;
    i_ack          = 1'b0;
    i_readdata     = 32'h0;
    d_ack          = 1'b0;
    d_readdata     = 32'h0;
    mem_address    = 32'h0;
    mem_read       = 1'b0;
    mem_write      = 1'b0;
    mem_writedata  = 32'h0;
    mem_byteenable = 4'h0;
    grant          = 2'b00;

    case (state)
      IDLE: begin
        // Streak only counts data grants taken while a fetch was waiting.
        if (!i_req) begin
          streak_nxt = '0;
        end
        if (d_req && (!i_req || (streak < STREAK_MAX))) begin
          state_nxt = BUSY_D;
        end else if (i_req) begin
          state_nxt = BUSY_I;
        end
      end

      BUSY_I: begin
        mem_address    = i_addr;
        mem_read       = 1'b1;
        mem_byteenable = 4'hF;
        grant          = 2'b01;
        if (!mem_waitrequest) begin
          i_ack      = 1'b1;
          i_readdata = mem_readdata;
          state_nxt  = IDLE;
          streak_nxt = '0;
        end
      end

      BUSY_D: begin
        mem_address    = d_addr;
        mem_read       = !d_write;
        mem_write      = d_write;
        mem_writedata  = d_writedata;
        mem_byteenable = d_byteenable;
        grant          = 2'b10;
        if (!mem_waitrequest) begin
          d_ack      = 1'b1;
          d_readdata = mem_readdata;
          state_nxt  = IDLE;
          if (i_req && (streak < STREAK_MAX)) begin
            streak_nxt = streak + STREAK_W'(1);
          end
        end
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_mips_mem_arbiter.sv
// Purpose : randomized + directed scoreboard bench for mips_mem_arbiter.
// Latency : expected ack cycles recorded for directed transactions.
// Backpressure: bench memory stalls via random mem_waitrequest.
module tb_mips_mem_arbiter;

  localparam int MAX = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        i_req;
  logic [31:0] i_addr;
  logic        i_ack;
  logic [31:0] i_readdata;
  logic        d_req;
  logic        d_write;
  logic [31:0] d_addr;
  logic [31:0] d_writedata;
  logic [3:0]  d_byteenable;
  logic        d_ack;
  logic [31:0] d_readdata;
  logic [31:0] mem_address;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_writedata;
  logic [3:0]  mem_byteenable;
  logic        mem_waitrequest;
  logic [31:0] mem_readdata;
  logic [1:0]  grant;

  mips_mem_arbiter #(.MAX_DATA_STREAK(MAX), .STREAK_W(3)) dut (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_readdata(i_readdata),
    .d_req(d_req), .d_write(d_write), .d_addr(d_addr), .d_writedata(d_writedata),
    .d_byteenable(d_byteenable), .d_ack(d_ack), .d_readdata(d_readdata),
    .mem_address(mem_address), .mem_read(mem_read), .mem_write(mem_write),
    .mem_writedata(mem_writedata), .mem_byteenable(mem_byteenable),
    .mem_waitrequest(mem_waitrequest), .mem_readdata(mem_readdata), .grant(grant)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int nvec  = 0;
  int nfail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- memory contents (environment) ----------------
  // Data array lives at 0x1000..0x103F; everything else is a fixed ROM pattern.
  function automatic bit in_array(input logic [31:0] a);
    return a[31:6] == 26'h40;
  endfunction

  function automatic logic [31:0] rom(input logic [31:0] a);
    if (a == 32'hBFC0_0000) return 32'h8C82_0004;
    if (a == 32'h0000_2004) return 32'h1234_5678;
    return (a * 32'h9E37_79B1) + 32'h1;
  endfunction

  logic [31:0] bmem    [16];   // memory seen by the DUT
  logic [31:0] ref_mem [16];   // reference model memory, updated in issue order

  always_comb begin
    if (!mem_read)                  mem_readdata = 32'hCAFE_F00D;
    else if (in_array(mem_address)) mem_readdata = bmem[mem_address[5:2]];
    else                            mem_readdata = rom(mem_address);
  end

  always @(posedge clk) begin
    if (reset && mem_write && !mem_waitrequest && in_array(mem_address)) begin
      for (int b = 0; b < 4; b++)
        if (mem_byteenable[b]) bmem[mem_address[5:2]][8*b +: 8] <= mem_writedata[8*b +: 8];
    end
  end

  // ---------------- scoreboard ----------------
  typedef struct {
    logic [31:0] data;
    bit          chk_data;
    int          exp_cyc;   // -1: cycle not checked
  } exp_t;

  exp_t iq[$];
  exp_t dq[$];
  byte  ack_log[$];
  bit   i_done = 0, d_done = 0;
  int   i_age = 0, d_age = 0;

  task automatic issue_i(input logic [31:0] a, input int ec);
    exp_t e;
    i_req = 1'b1; i_addr = a;
    e.data = rom(a); e.chk_data = 1; e.exp_cyc = ec;
    iq.push_back(e);
  endtask

  task automatic issue_d(input logic w, input logic [31:0] a, input logic [31:0] wd,
                         input logic [3:0] be, input int ec);
    exp_t e;
    d_req = 1'b1; d_write = w; d_addr = a; d_writedata = wd; d_byteenable = be;
    e.chk_data = !w; e.exp_cyc = ec; e.data = 32'h0;
    if (w) begin
      for (int b = 0; b < 4; b++)
        if (be[b]) ref_mem[a[5:2]][8*b +: 8] = wd[8*b +: 8];
    end else begin
      e.data = in_array(a) ? ref_mem[a[5:2]] : rom(a);
    end
    dq.push_back(e);
  endtask

  task automatic issue_rand_d();
    issue_d(1'($urandom % 2), 32'h1000 + 4 * ($urandom % 16), $urandom, 4'($urandom % 16), -1);
  endtask

  task automatic issue_rand_i();
    issue_i(32'hBFC0_0000 + 4 * ($urandom % 256), -1);
  endtask

  task automatic finish_now();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  endtask

  // Advance one cycle; retire or refill requests acknowledged last cycle.
  task automatic tick(input bit refill);
    @(posedge clk); #1;
    if (d_done) begin
      d_done = 0;
      if (refill) issue_rand_d(); else d_req = 1'b0;
    end
    if (i_done) begin
      i_done = 0;
      if (refill) issue_rand_i(); else i_req = 1'b0;
    end
    i_age = i_req ? i_age + 1 : 0;
    d_age = d_req ? d_age + 1 : 0;
    if (i_age > 300 || d_age > 300) begin
      nvec++; nfail++;
      $display("FAIL req_timeout: i_age %0d d_age %0d, required <= 300", i_age, d_age);
      finish_now();
    end
  endtask

  // ---------------- monitor ----------------
  int dstreak = 0;
  always @(negedge clk) begin
    exp_t e;
    chk("ack_exclusive", {31'b0, i_ack & d_ack}, 32'h0);
    chk("strobe_exclusive", {31'b0, mem_read & mem_write}, 32'h0);

    if (!reset || !i_req) dstreak = 0;

    if (d_ack) begin
      ack_log.push_back("D");
      if (i_req) begin
        dstreak++;
        chk("data_streak_bound", {31'b0, dstreak <= MAX}, 32'h1);
      end
      if (dq.size() == 0) begin
        chk("d_ack_expected", {31'b0, d_ack}, 32'h0);
      end else begin
        e = dq.pop_front();
        if (e.chk_data) chk("d_readdata", d_readdata, e.data);
        if (e.exp_cyc >= 0) chk("d_ack_cycle", cyc, e.exp_cyc);
        d_done = 1;
      end
    end else begin
      chk("d_readdata_idle", d_readdata, 32'h0);
    end

    if (i_ack) begin
      ack_log.push_back("I");
      dstreak = 0;
      if (iq.size() == 0) begin
        chk("i_ack_expected", {31'b0, i_ack}, 32'h0);
      end else begin
        e = iq.pop_front();
        chk("i_readdata", i_readdata, e.data);
        if (e.exp_cyc >= 0) chk("i_ack_cycle", cyc, e.exp_cyc);
        i_done = 1;
      end
    end else begin
      chk("i_readdata_idle", i_readdata, 32'h0);
    end

    // Memory side must reflect exactly one outstanding request.
    if (mem_write) begin
      chk("wr_owner", {31'b0, d_req & d_write}, 32'h1);
      chk("wr_addr", mem_address, d_addr);
      chk("wr_data", mem_writedata, d_writedata);
      chk("wr_be", {28'b0, mem_byteenable}, {28'b0, d_byteenable});
      chk("wr_grant", {30'b0, grant}, 32'h2);
    end else if (mem_read && i_req && mem_address == i_addr) begin
      chk("if_be", {28'b0, mem_byteenable}, 32'hF);
      chk("if_wdata", mem_writedata, 32'h0);
      chk("if_grant", {30'b0, grant}, 32'h1);
    end else if (mem_read) begin
      chk("rd_owner", {31'b0, d_req & !d_write}, 32'h1);
      chk("rd_addr", mem_address, d_addr);
      chk("rd_be", {28'b0, mem_byteenable}, {28'b0, d_byteenable});
      chk("rd_grant", {30'b0, grant}, 32'h2);
    end else begin
      chk("idle_grant", {30'b0, grant}, 32'h0);
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    byte exp_seq[$];
    int  ds;
    int  k;

    for (int w = 0; w < 16; w++) begin
      bmem[w]    = 32'h1111_0000 + w;
      ref_mem[w] = 32'h1111_0000 + w;
    end

    // Reset with requests active: all outputs must stay 0.
    reset = 1'b0;
    i_req = 1'b1; i_addr = 32'hBFC0_0040;
    d_req = 1'b1; d_write = 1'b1; d_addr = 32'h1000; d_writedata = 32'hFFFF_FFFF;
    d_byteenable = 4'hF; mem_waitrequest = 1'b0;
    #3;
    chk("rst_mem_read", {31'b0, mem_read}, 32'h0);
    chk("rst_mem_write", {31'b0, mem_write}, 32'h0);
    chk("rst_mem_address", mem_address, 32'h0);
    chk("rst_mem_writedata", mem_writedata, 32'h0);
    chk("rst_mem_be", {28'b0, mem_byteenable}, 32'h0);
    chk("rst_i_ack", {31'b0, i_ack}, 32'h0);
    chk("rst_d_ack", {31'b0, d_ack}, 32'h0);
    chk("rst_grant", {30'b0, grant}, 32'h0);
    @(posedge clk); @(posedge clk); #1;
    chk("rst_hold_write", {31'b0, mem_write}, 32'h0);
    chk("rst_hold_grant", {30'b0, grant}, 32'h0);
    i_req = 1'b0; d_req = 1'b0;
    #2 reset = 1'b1;

    // Single fetch, no stall: ack one cycle after grant edge.
    tick(0);
    issue_i(32'hBFC0_0000, cyc + 1);
    tick(0);
    @(negedge clk);
    chk("fetch_mem_read", {31'b0, mem_read}, 32'h1);
    chk("fetch_grant", {30'b0, grant}, 32'h1);
    tick(0);
    @(negedge clk);
    chk("fetch_grant_after", {30'b0, grant}, 32'h0);

    // Store stalled three cycles: write strobe held four cycles, ack in the last.
    tick(0);
    issue_d(1'b1, 32'h1000, 32'hDEAD_BEEF, 4'b0011, cyc + 4);
    for (int j = 0; j < 4; j++) begin
      tick(0);
      mem_waitrequest = (j < 3);
      @(negedge clk);
      chk("stall_mem_write", {31'b0, mem_write}, 32'h1);
      chk("stall_mem_read", {31'b0, mem_read}, 32'h0);
      chk("stall_d_ack", {31'b0, d_ack}, {31'b0, j == 3});
    end
    tick(0);

    // Contention: data first, then one dead cycle, then fetch.
    mem_waitrequest = 1'b0;
    issue_d(1'b0, 32'h1004, 32'h0, 4'hF, cyc + 1);
    issue_i(32'hBFC0_0010, cyc + 3);
    tick(0); @(negedge clk); chk("cont_grant_d", {30'b0, grant}, 32'h2);
    tick(0); @(negedge clk); chk("cont_grant_idle", {30'b0, grant}, 32'h0);
    tick(0); @(negedge clk); chk("cont_grant_i", {30'b0, grant}, 32'h1);
    tick(0);

    // Load from ROM region.
    issue_d(1'b0, 32'h0000_2004, 32'h0, 4'hF, cyc + 1);
    tick(0); @(negedge clk); chk("load_mem_read", {31'b0, mem_read}, 32'h1);
    tick(0); @(negedge clk); chk("load_rdata_after", d_readdata, 32'h0);

    // Starvation bound: both always pending, data refilled after every ack.
    ack_log.delete();
    issue_rand_i();
    issue_rand_d();
    for (int n = 0; n < 200 && ack_log.size() < 10; n++) begin
      tick(1);
      mem_waitrequest = ($urandom % 3 == 0);
    end
    ds = 0;
    for (int n = 0; n < 10; n++) begin
      if (ds < MAX) begin exp_seq.push_back("D"); ds++; end
      else begin exp_seq.push_back("I"); ds = 0; end
    end
    chk("starve_log_len", {31'b0, ack_log.size() >= 10}, 32'h1);
    for (int n = 0; n < 10 && n < ack_log.size(); n++)
      chk($sformatf("starve_order_%0d", n), {24'b0, ack_log[n]}, {24'b0, exp_seq[n]});
    mem_waitrequest = 1'b0;
    for (int n = 0; n < 50 && (i_req || d_req); n++) tick(0);

    // Asynchronous reset in the middle of a stalled store.
    tick(0);
    issue_d(1'b1, 32'h1008, 32'hA5A5_0001, 4'hF, -1);
    tick(0);
    mem_waitrequest = 1'b1;
    #2;
    chk("arst_pre_write", {31'b0, mem_write}, 32'h1);
    reset = 1'b0;
    #1;
    chk("arst_mem_write", {31'b0, mem_write}, 32'h0);
    chk("arst_grant", {30'b0, grant}, 32'h0);
    chk("arst_d_ack", {31'b0, d_ack}, 32'h0);
    chk("arst_i_ack", {31'b0, i_ack}, 32'h0);
    @(posedge clk); #1;
    reset = 1'b1;
    mem_waitrequest = 1'b0;
    k = 0;
    while (d_req && k < 20) begin tick(0); k++; end
    chk("arst_restart_done", {31'b0, d_req}, 32'h0);
    tick(0); tick(0);

    // Random traffic.
    for (int n = 0; n < 1500; n++) begin
      tick(0);
      mem_waitrequest = ($urandom % 3 == 0);
      if (!d_req && ($urandom % 2)) issue_rand_d();
      if (!i_req && ($urandom % 2)) issue_rand_i();
    end

    // Drain and final consistency.
    mem_waitrequest = 1'b0;
    for (int n = 0; n < 100 && (i_req || d_req); n++) tick(0);
    tick(0); tick(0);
    chk("drain_iq_empty", iq.size(), 32'h0);
    chk("drain_dq_empty", dq.size(), 32'h0);
    for (int w = 0; w < 16; w++)
      chk($sformatf("mem_word_%0d", w), bmem[w], ref_mem[w]);

    finish_now();
  end

endmodule
